simd_proc_param: RTL and testbench

- Parametrised successor to the fixed 5-lane SIMD processor element.
- Accepts a setup instruction sequence from the issuer: LD src0, LD src1, INFO, STORE dst.
- Streams vectors from shared memory through a LANES-wide element-wise ALU and writes results back with partial-width tail handling.
- Adds signed saturation mode, setup-opcode error reporting, a zero-count fast path and grant-stalled fetches on both read beats.

---
 rtl/simd_proc_param.sv | 191 +++++++++++++++++++
 tb/tb_simd_proc_param.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_proc_param.sv
// LANES-wide SIMD processing element: takes a LD/LD/INFO/STORE setup from the issuer,
// then streams operand beats from shared memory through a per-lane ALU and writes results back.
module simd_proc_param #(
  parameter  int LANES  = 5,
  parameter  int ELEM_W = 16,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 16,
  parameter  int PAY_W  = 32,
  localparam int SZ_W   = $clog2(LANES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [1:0]              i_instr_op,
  input  logic [PAY_W-1:0]        i_payload,
  input  logic                    i_grant_rd,
  input  logic                    i_grant_wr,
  input  logic [LANES*ELEM_W-1:0] i_data,
  output logic [ADDR_W-1:0]       o_addr,
  output logic                    o_req_rd,
  output logic                    o_req_wr,
  output logic                    o_wr_en,
  output logic [SZ_W-1:0]         o_wr_size,
  output logic [LANES*ELEM_W-1:0] o_data,
  output logic                    o_busy,
  output logic                    o_finish,
  output logic                    o_err
);

  localparam logic [1:0] OP_LD    = 2'd0;
  localparam logic [1:0] OP_INFO  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam logic signed [2*ELEM_W-1:0] SMAX = {{(ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [2*ELEM_W-1:0] SMIN = {{(ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_INFO, S_STORE, S_FETCH0, S_FETCH1, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]       addr0_q, addr1_q, wr_addr_q;
  logic [CNT_W-1:0]        count_q;
  logic [1:0]              op_q;
  logic                    sat_q;
  logic [LANES*ELEM_W-1:0] reg0_q, reg1_q;
  logic                    err_q;

  logic                    setup, accept, bad, last_beat;
  logic [1:0]              exp_op;
  logic [SZ_W-1:0]         wr_size_c;
  logic [LANES*ELEM_W-1:0] alu_data;

  logic unused_pay;
  assign unused_pay = ^i_payload;

  // Setup decode: NOP is silently ignored, any other mismatch (or INFO op=3) flags an error
  always_comb begin
    setup  = 1'b0;
    exp_op = OP_NOP;
    case (state_q)
      S_LD0, S_LD1: begin setup = 1'b1; exp_op = OP_LD;    end
      S_INFO:       begin setup = 1'b1; exp_op = OP_INFO;  end
      S_STORE:      begin setup = 1'b1; exp_op = OP_STORE; end
      default:      ;
    endcase
    accept = setup && i_valid && (i_instr_op == exp_op) &&
             !((state_q == S_INFO) && (i_payload[1:0] == 2'd3));
    bad    = setup && i_valid && (i_instr_op != OP_NOP) && !accept;
  end

  assign last_beat = (count_q <= CNT_W'(LANES));
  assign wr_size_c = last_beat ? SZ_W'(count_q) : SZ_W'(LANES);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_en)       state_d = S_LD0;
      S_LD0:    if (accept)     state_d = S_LD1;
      S_LD1:    if (accept)     state_d = S_INFO;
      S_INFO:   if (accept)     state_d = S_STORE;
      S_STORE:  if (accept)     state_d = (count_q == '0) ? S_DONE : S_FETCH0;
      S_FETCH0: if (i_grant_rd) state_d = S_FETCH1;
      S_FETCH1: if (i_grant_rd) state_d = S_WRITE;
      S_WRITE:  if (i_grant_wr) state_d = last_beat ? S_DONE : S_FETCH0;
      S_DONE:   if (i_valid)    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr0_q   <= '0;
      addr1_q   <= '0;
      wr_addr_q <= '0;
      count_q   <= '0;
      op_q      <= '0;
      sat_q     <= 1'b0;
      reg0_q    <= '0;
      reg1_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= bad;
      if (accept) begin
        case (state_q)
          S_LD0:   addr0_q   <= i_payload[ADDR_W-1:0];
          S_LD1:   addr1_q   <= i_payload[ADDR_W-1:0];
          S_STORE: wr_addr_q <= i_payload[ADDR_W-1:0];
          S_INFO: begin
            count_q <= i_payload[CNT_W+2:3];
            sat_q   <= i_payload[2];
            op_q    <= i_payload[1:0];
          end
          default: ;
        endcase
      end
      if (state_q == S_FETCH0 && i_grant_rd) reg0_q <= i_data;
      if (state_q == S_FETCH1 && i_grant_rd) reg1_q <= i_data;
      if (state_q == S_WRITE && i_grant_wr) begin
        addr0_q   <= addr0_q   + ADDR_W'(LANES);
        addr1_q   <= addr1_q   + ADDR_W'(LANES);
        wr_addr_q <= wr_addr_q + ADDR_W'(LANES);
        if (!last_beat) count_q <= count_q - CNT_W'(LANES);
      end
    end
  end

  // Operands are sign-extended to 2*ELEM_W so add/sub/mul are exact before clamping
  always_comb begin
    logic [ELEM_W-1:0]          la, lb;
    logic signed [2*ELEM_W-1:0] aw, bw, wide;
    alu_data = '0;
    la       = '0;
    lb       = '0;
    aw       = '0;
    bw       = '0;
    wide     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      la = reg0_q[(LANES-1-i)*ELEM_W +: ELEM_W];
      lb = reg1_q[(LANES-1-i)*ELEM_W +: ELEM_W];
      aw = {{ELEM_W{la[ELEM_W-1]}}, la};
      bw = {{ELEM_W{lb[ELEM_W-1]}}, lb};
      case (op_q)
        2'd0:    wide = aw + bw;
        2'd1:    wide = aw - bw;
        2'd2:    wide = aw * bw;
        default: wide = '0;
      endcase
      if (sat_q) begin
        if (wide > SMAX)      wide = SMAX;
        else if (wide < SMIN) wide = SMIN;
      end
      if (SZ_W'(i) < wr_size_c)
        alu_data[(LANES-1-i)*ELEM_W +: ELEM_W] = wide[ELEM_W-1:0];
    end
  end

  always_comb begin
    o_addr    = '0;
    o_req_rd  = 1'b0;
    o_req_wr  = 1'b0;
    o_wr_en   = 1'b0;
    o_wr_size = '0;
    o_data    = '0;
    o_finish  = 1'b0;
    o_busy    = (state_q != S_IDLE);
    o_err     = err_q;
    case (state_q)
      S_FETCH0: begin o_req_rd = 1'b1; o_addr = addr0_q; end
      S_FETCH1: begin o_req_rd = 1'b1; o_addr = addr1_q; end
      S_WRITE: begin
        o_req_wr  = 1'b1;
        o_addr    = wr_addr_q;
        o_wr_en   = i_grant_wr;
        o_wr_size = wr_size_c;
        o_data    = alu_data;
      end
      S_DONE:   o_finish = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_simd_proc_param.sv
// Scoreboard bench for simd_proc_param: a memory model feeds reads, a reference model
// predicts every write beat, and a negedge monitor pops and compares.
module tb_simd_proc_param;

  localparam int LANES = 5;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W = 16;
  localparam int PAY_W = 32;
  localparam int SZ_W = 3;
  localparam int DW = LANES * ELEM_W;

  logic              clk;
  logic              i_rst, i_en, i_valid, i_grant_rd, i_grant_wr;
  logic [1:0]        i_instr_op;
  logic [PAY_W-1:0]  i_payload;
  logic [DW-1:0]     i_data;
  logic [ADDR_W-1:0] o_addr;
  logic              o_req_rd, o_req_wr, o_wr_en, o_busy, o_finish, o_err;
  logic [SZ_W-1:0]   o_wr_size;
  logic [DW-1:0]     o_data;

  simd_proc_param #(
    .LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .PAY_W(PAY_W)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .i_instr_op(i_instr_op),
    .i_payload(i_payload), .i_grant_rd(i_grant_rd), .i_grant_wr(i_grant_wr), .i_data(i_data),
    .o_addr(o_addr), .o_req_rd(o_req_rd), .o_req_wr(o_req_wr), .o_wr_en(o_wr_en),
    .o_wr_size(o_wr_size), .o_data(o_data), .o_busy(o_busy), .o_finish(o_finish), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   addr;
    logic [2:0]    size;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         sb_q[$];
  logic [15:0] mem [0:65535];
  int checks = 0, errors = 0;
  int rd_grants = 0, rd_reqs = 0, err_cycles = 0, rstall_cnt = 0, wstall_cnt = 0;
  int rd1_hold = 0, wr_hold = 0;
  logic [15:0] rd1_addr = '0;
  bit rand_stall = 1'b0;

  function automatic void check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] model_lane(input logic [15:0] a, input logic [15:0] b,
                                             input int op, input bit sat);
    longint x, y, r;
    x = $signed(a);
    y = $signed(b);
    case (op)
      0:       r = x + y;
      1:       r = x - y;
      default: r = x * y;
    endcase
    if (sat) begin
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
    end
    return r[15:0];
  endfunction

  function automatic logic [DW-1:0] pack(input logic [15:0] addr);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) d[(LANES-1-i)*ELEM_W +: ELEM_W] = mem[16'(addr + i)];
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side: grants and read data, with optional random or directed stalls
  initial begin
    i_grant_rd = 1'b0;
    i_grant_wr = 1'b0;
    i_data     = '0;
    forever begin
      bit g;
      @(posedge clk);
      #1;
      g = 1'b0;
      if (o_req_rd) begin
        if (rd1_hold > 0 && o_addr == rd1_addr) rd1_hold--;
        else g = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      i_grant_rd = g;
      i_data     = pack(o_addr);
      g = 1'b0;
      if (o_req_wr) begin
        if (wr_hold > 0) wr_hold--;
        else g = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      i_grant_wr = g;
    end
  end

  // Monitor: scoreboard pops on each granted write, plus stall-stability checks
  initial begin
    bit prev_rstall, prev_wstall;
    logic [15:0]   prev_raddr, prev_waddr;
    logic [2:0]    prev_wsize;
    logic [DW-1:0] prev_wdata;
    wr_t e;
    prev_rstall = 1'b0;
    prev_wstall = 1'b0;
    forever begin
      @(negedge clk);
      if (o_err) err_cycles++;
      if (o_req_rd) rd_reqs++;
      if (o_req_rd && i_grant_rd) rd_grants++;
      if (o_req_rd && !i_grant_rd) begin
        rstall_cnt++;
        if (prev_rstall) check_i("rd_addr_hold", int'(o_addr), int'(prev_raddr));
        prev_rstall = 1'b1;
        prev_raddr  = o_addr;
      end else prev_rstall = 1'b0;
      if (o_req_wr && !i_grant_wr) begin
        wstall_cnt++;
        check_i("wr_en_stall", int'(o_wr_en), 0);
        if (prev_wstall) begin
          check_i("wr_addr_hold", int'(o_addr), int'(prev_waddr));
          check_i("wr_size_hold", int'(o_wr_size), int'(prev_wsize));
          check_v("wr_data_hold", o_data, prev_wdata);
        end
        prev_wstall = 1'b1;
        prev_waddr  = o_addr;
        prev_wsize  = o_wr_size;
        prev_wdata  = o_data;
      end else prev_wstall = 1'b0;
      if (o_wr_en) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write at %h expected none", o_addr);
        end else begin
          e = sb_q.pop_front();
          check_i("wr_addr", int'(o_addr), int'(e.addr));
          check_i("wr_size", int'(o_wr_size), int'(e.size));
          check_v("wr_data", o_data, e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  task automatic send(input logic [1:0] op, input logic [PAY_W-1:0] p);
    i_valid    = 1'b1;
    i_instr_op = op;
    i_payload  = p;
    tick();
    i_valid    = 1'b0;
    i_instr_op = 2'd3;
  endtask

  function automatic logic [PAY_W-1:0] info_pay(input int op, input bit sat, input int cnt);
    logic [PAY_W-1:0] p;
    p = $urandom;
    p[CNT_W+2:3] = 16'(cnt);
    p[2] = sat;
    p[1:0] = 2'(op);
    return p;
  endfunction

  function automatic logic [PAY_W-1:0] addr_pay(input logic [15:0] a);
    logic [PAY_W-1:0] p;
    p = $urandom;
    p[15:0] = a;
    return p;
  endfunction

  task automatic expect_writes(input logic [15:0] a0, input logic [15:0] a1, input int op,
                               input bit sat, input int cnt, input logic [15:0] wr);
    int beats, sz;
    wr_t e;
    beats = (cnt + LANES - 1) / LANES;
    for (int k = 0; k < beats; k++) begin
      sz = (cnt - k*LANES < LANES) ? cnt - k*LANES : LANES;
      e.addr = 16'(wr + k*LANES);
      e.size = 3'(sz);
      e.data = '0;
      for (int i = 0; i < sz; i++)
        e.data[(LANES-1-i)*ELEM_W +: ELEM_W] =
          model_lane(mem[16'(a0 + k*LANES + i)], mem[16'(a1 + k*LANES + i)], op, sat);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_cmd(input logic [15:0] a0, input logic [15:0] a1, input int op, input bit sat,
                         input int cnt, input logic [15:0] wr, input bit hold_en, input bit inject);
    int rd0, rq0, er0, n;
    expect_writes(a0, a1, op, sat, cnt, wr);
    rd0 = rd_grants;
    rq0 = rd_reqs;
    er0 = err_cycles;
    i_en = 1'b1;
    tick();
    i_en = hold_en;
    send(2'd0, addr_pay(a0));
    if (inject) begin
      send(2'd1, info_pay(op, sat, cnt));
      check_i("err_pulse_ld1", int'(o_err), 1);
      send(2'd3, $urandom);
      check_i("err_nop_quiet", int'(o_err), 0);
    end
    send(2'd0, addr_pay(a1));
    if (inject) begin
      send(2'd1, info_pay(3, sat, cnt));
      check_i("err_pulse_op3", int'(o_err), 1);
      send(2'd2, addr_pay(wr));
      check_i("err_pulse_info", int'(o_err), 1);
    end
    send(2'd1, info_pay(op, sat, cnt));
    send(2'd2, addr_pay(wr));
    if (cnt == 0) check_i("zero_cnt_finish", int'(o_finish), 1);
    n = 0;
    while (!o_finish && n < 4000) begin
      tick();
      n++;
    end
    check_i("finish_seen", int'(o_finish), 1);
    check_i("rd_beats", rd_grants - rd0, 2 * ((cnt + LANES - 1) / LANES));
    check_i("sb_drained", sb_q.size(), 0);
    check_i("err_cycles", err_cycles - er0, inject ? 3 : 0);
    if (cnt == 0) check_i("zero_cnt_no_rd", rd_reqs - rq0, 0);
    sb_q.delete();
    i_en       = 1'b0;
    i_valid    = 1'b1;
    i_instr_op = 2'($urandom);
    tick();
    i_valid    = 1'b0;
    i_instr_op = 2'd3;
    check_i("idle_busy", int'(o_busy), 0);
    check_i("idle_finish", int'(o_finish), 0);
  endtask

  initial begin
    int rs0, ws0, n;
    i_rst = 1'b1;
    i_en = 1'b0;
    i_valid = 1'b0;
    i_instr_op = 2'd3;
    i_payload = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    repeat (3) tick();
    check_i("rst_busy", int'(o_busy), 0);
    check_i("rst_finish", int'(o_finish), 0);
    check_i("rst_req_rd", int'(o_req_rd), 0);
    check_i("rst_req_wr", int'(o_req_wr), 0);
    check_i("rst_wr_en", int'(o_wr_en), 0);
    check_i("rst_err", int'(o_err), 0);
    check_i("rst_addr", int'(o_addr), 0);
    check_i("rst_wr_size", int'(o_wr_size), 0);
    check_v("rst_data", o_data, '0);
    i_rst = 1'b0;
    tick();

    run_cmd(16'd100, 16'd200, 0, 1'b0, 12, 16'd300, 1'b0, 1'b0);

    for (int i = 0; i < LANES; i++) begin
      mem[1000 + i] = 16'h8000;
      mem[2000 + i] = 16'h0001;
      mem[1100 + i] = 16'd300;
      mem[1200 + i] = 16'd300;
    end
    run_cmd(16'd1000, 16'd2000, 1, 1'b1, 5, 16'd3000, 1'b0, 1'b0);
    run_cmd(16'd1000, 16'd2000, 1, 1'b0, 5, 16'd3000, 1'b0, 1'b0);
    run_cmd(16'd1100, 16'd1200, 2, 1'b1, 5, 16'd3100, 1'b0, 1'b0);
    run_cmd(16'd1100, 16'd1200, 2, 1'b0, 4, 16'd3100, 1'b0, 1'b0);

    run_cmd(16'd400, 16'd500, 1, 1'b0, 7, 16'd600, 1'b1, 1'b1);
    run_cmd(16'd700, 16'd800, 0, 1'b0, 0, 16'd900, 1'b0, 1'b0);

    rs0 = rstall_cnt;
    ws0 = wstall_cnt;
    rd1_addr = 16'd2200;
    rd1_hold = 3;
    wr_hold  = 4;
    run_cmd(16'd2100, 16'd2200, 0, 1'b1, 3, 16'd2300, 1'b0, 1'b0);
    check_i("rd1_stall_cycles", rstall_cnt - rs0, 3);
    check_i("wr_stall_cycles", wstall_cnt - ws0, 4);

    wr_hold = 1_000_000;
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    send(2'd0, addr_pay(16'd5000));
    send(2'd0, addr_pay(16'd6000));
    send(2'd1, info_pay(0, 1'b0, 7));
    send(2'd2, addr_pay(16'd7000));
    n = 0;
    while (!o_req_wr && n < 100) begin
      tick();
      n++;
    end
    check_i("reach_write", int'(o_req_wr), 1);
    tick();
    i_rst = 1'b1;
    tick();
    check_i("midrst_busy", int'(o_busy), 0);
    check_i("midrst_req_wr", int'(o_req_wr), 0);
    check_i("midrst_req_rd", int'(o_req_rd), 0);
    check_i("midrst_wr_en", int'(o_wr_en), 0);
    check_v("midrst_data", o_data, '0);
    i_rst = 1'b0;
    wr_hold = 0;
    sb_q.delete();
    tick();
    run_cmd(16'd5000, 16'd6000, 0, 1'b0, 7, 16'd7000, 1'b0, 1'b0);

    rand_stall = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int cnt;
      cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(1, 40));
      run_cmd(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              cnt, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
